// File: rtl/wt_ram_ctrl.sv
// wt_ram_ctrl -- sequencer/arbiter for the transposed-weight RAM.
//
// Owns the RAM control port and serves two requesters:
//   * weight loader: streams columns of one layer (col_valid/col_ready),
//     each accepted column becomes one registered RAM column write.
//   * forward-pass engine: fetches rows of one layer, one row per
//     row_valid/row_ready handshake, with a registered row_data.
// Tracks which layers hold a complete set of weights (loaded).
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   load_start/layer/ncols          column-load request (sampled in IDLE)
//   col_valid, col_ready, col_data  column stream handshake and vector
//   fetch_start/layer/nrows         row-fetch request (sampled in IDLE)
//   row_valid, row_ready, row_data  row stream handshake and vector
//   ram_rw, ram_layer, ram_neuron,
//   ram_column, ram_col_data        registered RAM control outputs
//   ram_rdata                       RAM row output (one cycle after address)
//   busy, done, err, loaded         status
module wt_ram_ctrl #(
    parameter int MAX_DEPTH   = 4,
    parameter int MAX_NEURONS = 8,
    parameter int DATA_W      = 16,
    localparam int LW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
    localparam int NW = $clog2(MAX_NEURONS + 1),
    localparam int VW = MAX_NEURONS * DATA_W
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 load_start,
    input  logic [LW-1:0]        load_layer,
    input  logic [NW-1:0]        load_ncols,
    input  logic                 col_valid,
    output logic                 col_ready,
    input  logic [VW-1:0]        col_data,
    input  logic                 fetch_start,
    input  logic [LW-1:0]        fetch_layer,
    input  logic [NW-1:0]        fetch_nrows,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [VW-1:0]        row_data,
    output logic                 ram_rw,
    output logic [LW-1:0]        ram_layer,
    output logic [NW-1:0]        ram_neuron,
    output logic [NW-1:0]        ram_column,
    output logic [VW-1:0]        ram_col_data,
    input  logic [VW-1:0]        ram_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [MAX_DEPTH-1:0] loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_FLUSH, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD
    } state_t;

    state_t state_reg, state_next;

    logic                 ram_rw_reg;
    logic [LW-1:0]        ram_layer_reg;
    logic [NW-1:0]        ram_neuron_reg;
    logic [NW-1:0]        ram_column_reg;
    logic [VW-1:0]        ram_col_data_reg;
    logic [VW-1:0]        row_data_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic [MAX_DEPTH-1:0] loaded_reg;
    logic [NW-1:0]        cnt_reg;    // column index k during load, row index r during fetch
    logic [NW-1:0]        count_reg;  // latched ncols / nrows

    logic load_ok, fetch_ok;
    logic accept_load, accept_fetch, reject;
    logic last_item;

    // Request validation; the range checks are done at 32 bits so they stay
    // meaningful when MAX_DEPTH is not a power of two.
    assign load_ok  = (32'(load_layer) < 32'(MAX_DEPTH)) && (load_ncols != '0)
                   && (32'(load_ncols) <= 32'(MAX_NEURONS));
    assign fetch_ok = (32'(fetch_layer) < 32'(MAX_DEPTH)) && (fetch_nrows != '0)
                   && (32'(fetch_nrows) <= 32'(MAX_NEURONS)) && loaded_reg[fetch_layer];

    // Load has priority: a simultaneous fetch is silently dropped, even when
    // the load itself is rejected.
    assign accept_load  = (state_reg == S_IDLE) && load_start && load_ok;
    assign accept_fetch = (state_reg == S_IDLE) && !load_start && fetch_start && fetch_ok;
    assign reject       = (state_reg == S_IDLE) &&
                          (load_start ? !load_ok : (fetch_start && !fetch_ok));

    assign last_item = (cnt_reg == count_reg - NW'(1));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_load)       state_next = S_LOAD;
                else if (accept_fetch) state_next = S_RD_ISSUE;
            end
            S_LOAD:       if (col_valid && last_item) state_next = S_LOAD_FLUSH;
            S_LOAD_FLUSH: state_next = S_IDLE;
            S_RD_ISSUE:   state_next = S_RD_WAIT;
            S_RD_WAIT:    state_next = S_RD_HOLD;
            S_RD_HOLD:    if (row_ready) state_next = last_item ? S_IDLE : S_RD_ISSUE;
            default:      state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        col_ready = (state_reg == S_LOAD);
        row_valid = (state_reg == S_RD_HOLD);
        busy      = (state_reg != S_IDLE);
    end

    // Registered datapath and status
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ram_rw_reg       <= 1'b0;
            ram_layer_reg    <= '0;
            ram_neuron_reg   <= '0;
            ram_column_reg   <= '0;
            ram_col_data_reg <= '0;
            row_data_reg     <= '0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            loaded_reg       <= '0;
            cnt_reg          <= '0;
            count_reg        <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= reject;
            case (state_reg)
                S_IDLE: begin
                    ram_rw_reg <= 1'b0;
                    if (accept_load) begin
                        ram_layer_reg          <= load_layer;
                        count_reg              <= load_ncols;
                        cnt_reg                <= '0;
                        loaded_reg[load_layer] <= 1'b0;
                    end else if (accept_fetch) begin
                        ram_layer_reg  <= fetch_layer;
                        ram_neuron_reg <= '0;
                        count_reg      <= fetch_nrows;
                        cnt_reg        <= '0;
                    end
                end
                S_LOAD: begin
                    // col_ready is high throughout LOAD, so col_valid alone
                    // marks a handshake.
                    ram_rw_reg <= col_valid;
                    if (col_valid) begin
                        ram_column_reg   <= cnt_reg;
                        ram_col_data_reg <= col_data;
                        cnt_reg          <= cnt_reg + NW'(1);
                    end
                end
                S_LOAD_FLUSH: begin
                    // The last column write is being committed this cycle.
                    ram_rw_reg                <= 1'b0;
                    loaded_reg[ram_layer_reg] <= 1'b1;
                    done_reg                  <= 1'b1;
                end
                S_RD_WAIT: row_data_reg <= ram_rdata;
                S_RD_HOLD: begin
                    if (row_ready) begin
                        if (last_item) begin
                            done_reg <= 1'b1;
                        end else begin
                            cnt_reg        <= cnt_reg + NW'(1);
                            ram_neuron_reg <= cnt_reg + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_rw       = ram_rw_reg;
    assign ram_layer    = ram_layer_reg;
    assign ram_neuron   = ram_neuron_reg;
    assign ram_column   = ram_column_reg;
    assign ram_col_data = ram_col_data_reg;
    assign row_data     = row_data_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign loaded       = loaded_reg;

endmodule
